// File: rtl/edic_pkg.sv
// -----------------------------------------------------------------------------
// edic_pkg
// Shared types for the 8-bit datapath control sequencer.
//   opcode_e    : instruction opcode field IR[7:5]
//   state_e     : sequencer FSM states
//   CC_*        : JMP condition codes carried in IR[4:3]
//   ctrl_word_t : one bundle holding every datapath control output
//   needs_imm() : true for opcodes followed by an immediate byte
// -----------------------------------------------------------------------------
package edic_pkg;

    typedef enum logic [2:0] {
        OP_NOP = 3'd0,
        OP_LDI = 3'd1,
        OP_MOV = 3'd2,
        OP_ALU = 3'd3,
        OP_CMP = 3'd4,
        OP_JMP = 3'd5,
        OP_SHF = 3'd6,
        OP_HLT = 3'd7
    } opcode_e;

    typedef enum logic [1:0] {
        ST_FETCH     = 2'd0,
        ST_FETCH_IMM = 2'd1,
        ST_EXEC      = 2'd2,
        ST_HALT      = 2'd3
    } state_e;

    localparam logic [1:0] CC_ALWAYS = 2'b00;
    localparam logic [1:0] CC_Z      = 2'b01;
    localparam logic [1:0] CC_N      = 2'b10;
    localparam logic [1:0] CC_NZ     = 2'b11;

    typedef struct packed {
        logic       alu_oe;
        logic       alu_sub;
        logic [1:0] alu_op;
        logic       alu_shift_left;
        logic       reg_wr0;
        logic       reg_wr1;
        logic       reg_bus_sel;
        logic       reg_bus_en;
        logic       alu_sel;
        logic [7:0] bus_override;
        logic       bus_override_en;
    } ctrl_word_t;

    function automatic logic needs_imm(input opcode_e op);
        return (op == OP_LDI) || (op == OP_JMP);
    endfunction

endpackage

// File: rtl/control_sequencer_instr_decode.sv
// -----------------------------------------------------------------------------
// instr_decode
// Combinational decode of the latched instruction into datapath controls.
//   i_exec       : sequencer is in its single EXEC cycle (all outputs 0 otherwise)
//   i_ir, i_imm  : latched instruction byte and immediate byte
//   i_flagN/Z    : latched ALU flags, used for JMP conditions
//   o_ctrl       : datapath control word
//   o_jumpTaken  : load PC from IMM at the end of this EXEC
//   o_flagWe     : capture live ALU flags at the end of this EXEC
// -----------------------------------------------------------------------------
module instr_decode
    import edic_pkg::*;
(
    input  logic       i_exec,
    input  logic [7:0] i_ir,
    input  logic [7:0] i_imm,
    input  logic       i_flagN,
    input  logic       i_flagZ,
    output ctrl_word_t o_ctrl,
    output logic       o_jumpTaken,
    output logic       o_flagWe
);

    opcode_e    w_op;
    logic       w_rd;
    logic       w_rs;
    logic [1:0] w_cond;

    assign w_op   = opcode_e'(i_ir[7:5]);
    assign w_rd   = i_ir[4];
    assign w_rs   = i_ir[3];
    assign w_cond = i_ir[4:3];

    always_comb begin
        o_ctrl      = '0;
        o_jumpTaken = 1'b0;
        o_flagWe    = 1'b0;
        if (i_exec) begin
            case (w_op)
                OP_LDI: begin
                    o_ctrl.bus_override_en = 1'b1;
                    o_ctrl.bus_override    = i_imm;
                    o_ctrl.reg_wr0         = ~w_rd;
                    o_ctrl.reg_wr1         = w_rd;
                end
                OP_MOV: begin
                    o_ctrl.reg_bus_en  = 1'b1;
                    o_ctrl.reg_bus_sel = w_rs;
                    o_ctrl.reg_wr0     = ~w_rd;
                    o_ctrl.reg_wr1     = w_rd;
                end
                OP_ALU: begin
                    o_ctrl.alu_sel = w_rd;
                    o_ctrl.alu_oe  = 1'b1;
                    o_ctrl.alu_sub = i_ir[2];
                    o_ctrl.alu_op  = i_ir[1:0];
                    o_ctrl.reg_wr0 = ~w_rd;
                    o_ctrl.reg_wr1 = w_rd;
                    o_flagWe       = 1'b1;
                end
                OP_CMP: begin
                    // rs goes over the bus to ALU B; result is discarded, only flags kept
                    o_ctrl.alu_sel     = w_rd;
                    o_ctrl.reg_bus_en  = 1'b1;
                    o_ctrl.reg_bus_sel = w_rs;
                    o_ctrl.alu_sub     = 1'b1;
                    o_ctrl.alu_op      = i_ir[1:0];
                    o_flagWe           = 1'b1;
                end
                OP_SHF: begin
                    o_ctrl.alu_sel        = w_rd;
                    o_ctrl.alu_oe         = 1'b1;
                    o_ctrl.alu_shift_left = i_ir[2];
                    o_ctrl.reg_wr0        = ~w_rd;
                    o_ctrl.reg_wr1        = w_rd;
                    o_flagWe              = 1'b1;
                end
                OP_JMP: begin
                    case (w_cond)
                        CC_ALWAYS: o_jumpTaken = 1'b1;
                        CC_Z:      o_jumpTaken = i_flagZ;
                        CC_N:      o_jumpTaken = i_flagN;
                        CC_NZ:     o_jumpTaken = ~i_flagZ;
                        default:   o_jumpTaken = 1'b0;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
// Fetches instruction bytes over a req/valid port, sequences FETCH /
// FETCH_IMM / EXEC / HALT and drives every datapath control input.
//   i_clk, i_reset            : clock, synchronous active-high reset
//   o_fetchReq/o_fetchAddr    : byte request at PC
//   i_fetchData/i_fetchValid  : byte return, accepted on req & valid
//   i_aluFlagN/Z              : live ALU flags, latched by ALU/CMP/SHF
//   o_ctrl*/o_busOverride*    : datapath controls, nonzero only in EXEC
//   o_halted                  : sequencer parked in HALT
// -----------------------------------------------------------------------------
module control_sequencer
    import edic_pkg::*;
#(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       i_clk,
    input  logic       i_reset,
    output logic       o_fetchReq,
    output logic [7:0] o_fetchAddr,
    input  logic [7:0] i_fetchData,
    input  logic       i_fetchValid,
    input  logic       i_aluFlagN,
    input  logic       i_aluFlagZ,
    output logic       o_ctrlAluOE,
    output logic       o_ctrlAluSub,
    output logic [1:0] o_ctrlAluOp,
    output logic       o_ctrlAluShiftLeft,
    output logic       o_ctrlRegWr0,
    output logic       o_ctrlRegWr1,
    output logic       o_ctrlRegBusSel,
    output logic       o_ctrlRegBusEn,
    output logic       o_ctrlAluSel,
    output logic [7:0] o_busOverride,
    output logic       o_busOverrideEn,
    output logic       o_halted
);

    state_e     r_state;
    state_e     w_nextState;
    logic [7:0] r_pc;
    logic [7:0] r_ir;
    logic [7:0] r_imm;
    logic       r_flagN;
    logic       r_flagZ;

    logic       w_accept;
    logic       w_exec;
    ctrl_word_t w_ctrl;
    logic       w_jumpTaken;
    logic       w_flagWe;

    assign w_accept    = o_fetchReq & i_fetchValid;
    assign w_exec      = (r_state == ST_EXEC);
    assign o_fetchAddr = r_pc;

    always_comb begin
        w_nextState = r_state;
        o_fetchReq  = 1'b0;
        o_halted    = 1'b0;
        case (r_state)
            ST_FETCH: begin
                o_fetchReq = 1'b1;
                // route on the incoming byte so a 2-byte op goes straight to FETCH_IMM
                if (i_fetchValid)
                    w_nextState = needs_imm(opcode_e'(i_fetchData[7:5])) ? ST_FETCH_IMM : ST_EXEC;
            end
            ST_FETCH_IMM: begin
                o_fetchReq = 1'b1;
                if (i_fetchValid) w_nextState = ST_EXEC;
            end
            ST_EXEC:  w_nextState = (opcode_e'(r_ir[7:5]) == OP_HLT) ? ST_HALT : ST_FETCH;
            ST_HALT:  o_halted = 1'b1;
            default:  w_nextState = ST_FETCH;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_FETCH;
            r_pc    <= RESET_PC;
            r_ir    <= '0;
            r_imm   <= '0;
            r_flagN <= 1'b0;
            r_flagZ <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if (w_accept) begin
                r_pc <= r_pc + 8'd1;
                if (r_state == ST_FETCH) r_ir  <= i_fetchData;
                else                     r_imm <= i_fetchData;
            end
            // accept and jump never coincide: jump only happens in EXEC
            if (w_jumpTaken) r_pc <= r_imm;
            if (w_flagWe) begin
                r_flagN <= i_aluFlagN;
                r_flagZ <= i_aluFlagZ;
            end
        end
    end

    instr_decode u_decode (
        .i_exec     (w_exec),
        .i_ir       (r_ir),
        .i_imm      (r_imm),
        .i_flagN    (r_flagN),
        .i_flagZ    (r_flagZ),
        .o_ctrl     (w_ctrl),
        .o_jumpTaken(w_jumpTaken),
        .o_flagWe   (w_flagWe)
    );

    assign o_ctrlAluOE        = w_ctrl.alu_oe;
    assign o_ctrlAluSub       = w_ctrl.alu_sub;
    assign o_ctrlAluOp        = w_ctrl.alu_op;
    assign o_ctrlAluShiftLeft = w_ctrl.alu_shift_left;
    assign o_ctrlRegWr0       = w_ctrl.reg_wr0;
    assign o_ctrlRegWr1       = w_ctrl.reg_wr1;
    assign o_ctrlRegBusSel    = w_ctrl.reg_bus_sel;
    assign o_ctrlRegBusEn     = w_ctrl.reg_bus_en;
    assign o_ctrlAluSel       = w_ctrl.alu_sel;
    assign o_busOverride      = w_ctrl.bus_override;
    assign o_busOverrideEn    = w_ctrl.bus_override_en;

    // only one driver may own the shared bus
    a_busExclusive: assert property (@(posedge i_clk) disable iff (i_reset)
        $onehot0({o_ctrlAluOE, o_ctrlRegBusEn, o_busOverrideEn}));

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

    localparam logic [7:0] RST_PC = 8'h00;

    logic       clk = 1'b0;
    logic       i_reset, i_fetchValid, i_aluFlagN, i_aluFlagZ;
    logic [7:0] i_fetchData;
    logic       o_fetchReq, o_halted;
    logic [7:0] o_fetchAddr, o_busOverride;
    logic       o_ctrlAluOE, o_ctrlAluSub, o_ctrlAluShiftLeft, o_ctrlRegWr0, o_ctrlRegWr1;
    logic       o_ctrlRegBusSel, o_ctrlRegBusEn, o_ctrlAluSel, o_busOverrideEn;
    logic [1:0] o_ctrlAluOp;

    always #5 clk = ~clk;

    control_sequencer #(.RESET_PC(RST_PC)) dut (
        .i_clk(clk), .i_reset(i_reset),
        .o_fetchReq(o_fetchReq), .o_fetchAddr(o_fetchAddr),
        .i_fetchData(i_fetchData), .i_fetchValid(i_fetchValid),
        .i_aluFlagN(i_aluFlagN), .i_aluFlagZ(i_aluFlagZ),
        .o_ctrlAluOE(o_ctrlAluOE), .o_ctrlAluSub(o_ctrlAluSub), .o_ctrlAluOp(o_ctrlAluOp),
        .o_ctrlAluShiftLeft(o_ctrlAluShiftLeft), .o_ctrlRegWr0(o_ctrlRegWr0),
        .o_ctrlRegWr1(o_ctrlRegWr1), .o_ctrlRegBusSel(o_ctrlRegBusSel),
        .o_ctrlRegBusEn(o_ctrlRegBusEn), .o_ctrlAluSel(o_ctrlAluSel),
        .o_busOverride(o_busOverride), .o_busOverrideEn(o_busOverrideEn),
        .o_halted(o_halted)
    );

    int vectors = 0;
    int miscompares = 0;

    // expectation for the current cycle, written by the stimulus, read by the checker
    bit          exp_chk = 1'b0;
    logic        exp_req, exp_halt;
    logic [7:0]  exp_addr;
    logic [18:0] exp_ctrl;
    logic [18:0] cap_ctrl;

    // ISA-level model state
    logic [7:0] mem [256];
    logic [7:0] m_pc, m_imm;
    logic       m_n, m_z, m_halt;

    // control word as seen by the datapath, in the bench's own field order
    function automatic logic [18:0] model_ctrl(input logic [7:0] ir, input logic [7:0] imm);
        logic aoe, asub, shl, wr0, wr1, bsel, ben, asel, oen;
        logic [1:0] aop;
        logic [7:0] ovr;
        {aoe, asub, shl, wr0, wr1, bsel, ben, asel, oen} = '0;
        aop = 2'b00; ovr = 8'h00;
        case (ir[7:5])
            3'd1: begin oen = 1; ovr = imm; wr0 = !ir[4]; wr1 = ir[4]; end
            3'd2: begin ben = 1; bsel = ir[3]; wr0 = !ir[4]; wr1 = ir[4]; end
            3'd3: begin asel = ir[4]; aoe = 1; asub = ir[2]; aop = ir[1:0]; wr0 = !ir[4]; wr1 = ir[4]; end
            3'd4: begin asel = ir[4]; ben = 1; bsel = ir[3]; asub = 1; aop = ir[1:0]; end
            3'd6: begin asel = ir[4]; aoe = 1; shl = ir[2]; wr0 = !ir[4]; wr1 = ir[4]; end
            default: ;
        endcase
        return {aoe, asub, aop, shl, wr0, wr1, bsel, ben, asel, ovr, oen};
    endfunction

    always @(negedge clk) begin
        logic [18:0] act;
        act = {o_ctrlAluOE, o_ctrlAluSub, o_ctrlAluOp, o_ctrlAluShiftLeft, o_ctrlRegWr0,
               o_ctrlRegWr1, o_ctrlRegBusSel, o_ctrlRegBusEn, o_ctrlAluSel, o_busOverride,
               o_busOverrideEn};
        cap_ctrl = act;
        if (exp_chk) begin
            vectors++;
            if (act !== exp_ctrl) begin
                miscompares++;
                $display("FAIL ctrl @%0t: got %h expected %h", $time, act, exp_ctrl);
            end
            vectors++;
            if ({o_fetchReq, o_fetchAddr} !== {exp_req, exp_addr}) begin
                miscompares++;
                $display("FAIL fetch @%0t: got req=%b addr=%h expected req=%b addr=%h",
                         $time, o_fetchReq, o_fetchAddr, exp_req, exp_addr);
            end
            vectors++;
            if (o_halted !== exp_halt) begin
                miscompares++;
                $display("FAIL halted @%0t: got %b expected %b", $time, o_halted, exp_halt);
            end
            vectors++;
            if ($countones({o_ctrlAluOE, o_ctrlRegBusEn, o_busOverrideEn}) > 1) begin
                miscompares++;
                $display("FAIL busexcl @%0t: got %b%b%b expected at most one set", $time,
                         o_ctrlAluOE, o_ctrlRegBusEn, o_busOverrideEn);
            end
        end
    end

    task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_exp(input logic req, input logic [18:0] ctrl, input logic halt);
        exp_chk = 1'b1; exp_req = req; exp_addr = m_pc; exp_ctrl = ctrl; exp_halt = halt;
    endtask

    task automatic rnd_noise();
        i_aluFlagN  = 1'($urandom_range(0, 1));
        i_aluFlagZ  = 1'($urandom_range(0, 1));
        i_fetchData = 8'($urandom);
    endtask

    task automatic do_reset();
        rnd_noise();
        i_fetchValid = 1'($urandom_range(0, 1));
        i_reset = 1'b1; exp_chk = 1'b0;
        tick();
        i_reset = 1'b0;
        m_pc = RST_PC; m_n = 0; m_z = 0; m_halt = 0; m_imm = 8'h00;
    endtask

    task automatic fetch_byte(output logic [7:0] b);
        int d = $urandom_range(0, 5);
        for (int i = 0; i < d; i++) begin
            rnd_noise(); i_fetchValid = 1'b0;
            set_exp(1'b1, 19'd0, 1'b0);
            tick();
        end
        rnd_noise(); i_fetchValid = 1'b1; i_fetchData = mem[m_pc];
        set_exp(1'b1, 19'd0, 1'b0);
        tick();
        b = mem[m_pc];
        m_pc = m_pc + 8'd1;
    endtask

    task automatic run_instr(input bit frc, input logic fn, input logic fz);
        logic [7:0] ir;
        logic n, z, tk;
        fetch_byte(ir);
        if (ir[7:5] == 3'd1 || ir[7:5] == 3'd5) fetch_byte(m_imm);
        rnd_noise();
        i_fetchValid = 1'($urandom_range(0, 1));
        n = frc ? fn : i_aluFlagN;
        z = frc ? fz : i_aluFlagZ;
        i_aluFlagN = n; i_aluFlagZ = z;
        set_exp(1'b0, model_ctrl(ir, m_imm), 1'b0);
        tick();
        case (ir[4:3])
            2'b00: tk = 1'b1;
            2'b01: tk = m_z;
            2'b10: tk = m_n;
            default: tk = !m_z;
        endcase
        if (ir[7:5] == 3'd5 && tk) m_pc = m_imm;
        if (ir[7:5] == 3'd3 || ir[7:5] == 3'd4 || ir[7:5] == 3'd6) begin m_n = n; m_z = z; end
        if (ir[7:5] == 3'd7) m_halt = 1'b1;
    endtask

    task automatic halt_cycles(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            rnd_noise(); i_fetchValid = 1'($urandom_range(0, 1));
            set_exp(1'b0, 19'd0, 1'b1);
            tick();
        end
    endtask

    initial begin
        logic [7:0] tmp;
        i_reset = 1'b1; i_fetchValid = 1'b0; i_fetchData = 8'h00;
        i_aluFlagN = 1'b0; i_aluFlagZ = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        do_reset();

        // idle: valid never arrives, sequencer waits at RESET_PC
        for (int i = 0; i < 20; i++) begin
            rnd_noise(); i_fetchValid = 1'b0;
            set_exp(1'b1, 19'd0, 1'b0);
            tick();
        end
        lit("idle_addr", {24'd0, o_fetchAddr}, 32'h00);
        lit("idle_req", {31'd0, o_fetchReq}, 32'h1);

        // LDI r0,#5A ; CMP r0,r0 ; JMP Z,#40 ; @40 JMP #FF ; @FF NOP
        mem[8'h00] = 8'h21; mem[8'h01] = 8'h5A; mem[8'h02] = 8'h82;
        mem[8'h03] = 8'hA8; mem[8'h04] = 8'h40; mem[8'h05] = 8'hE0;
        mem[8'h40] = 8'hA0; mem[8'h41] = 8'hFF; mem[8'hFF] = 8'h00;
        run_instr(0, 0, 0);
        lit("ldi_ctrl", {13'd0, cap_ctrl}, {13'd0, 19'b0_0_00_0_1_0_0_0_0_01011010_1});
        lit("ldi_next", {24'd0, o_fetchAddr}, 32'h02);
        run_instr(1, 0, 1);
        lit("cmp_ctrl", {13'd0, cap_ctrl}, {13'd0, 19'b0_1_10_0_0_0_0_1_0_00000000_0});
        run_instr(0, 0, 0);
        lit("jmpz_taken", {24'd0, o_fetchAddr}, 32'h40);
        run_instr(0, 0, 0);
        lit("jmp_always", {24'd0, o_fetchAddr}, 32'hFF);
        run_instr(0, 0, 0);
        lit("pc_wrap", {24'd0, o_fetchAddr}, 32'h00);

        // same program, CMP leaves Z clear -> jump falls through
        do_reset();
        run_instr(0, 0, 0);
        run_instr(1, 0, 0);
        run_instr(0, 0, 0);
        lit("jmpz_not_taken", {24'd0, o_fetchAddr}, 32'h05);
        run_instr(0, 0, 0);
        lit("hlt_halted", {31'd0, o_halted}, 32'h1);
        lit("hlt_req", {31'd0, o_fetchReq}, 32'h0);
        halt_cycles(10);
        lit("hlt_held", {31'd0, o_halted}, 32'h1);

        // reset while the immediate byte is being returned
        do_reset();
        mem[8'h00] = 8'h82; mem[8'h01] = 8'h21; mem[8'h02] = 8'h77;
        run_instr(1, 0, 1);
        fetch_byte(tmp);
        rnd_noise(); i_fetchValid = 1'b1; i_fetchData = mem[m_pc];
        set_exp(1'b1, 19'd0, 1'b0);
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        m_pc = RST_PC; m_n = 0; m_z = 0; m_halt = 0; m_imm = 8'h00;
        lit("rst_mid_addr", {24'd0, o_fetchAddr}, {24'd0, RST_PC});
        lit("rst_mid_req", {31'd0, o_fetchReq}, 32'h1);
        mem[8'h00] = 8'hA8; mem[8'h01] = 8'h40;
        run_instr(0, 0, 0);
        lit("rst_flags_clear", {24'd0, o_fetchAddr}, 32'h02);

        // random programs over all opcodes with random fetch latency
        do_reset();
        for (int k = 0; k < 400; k++) begin
            if (k % 50 == 0) begin
                for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
                do_reset();
            end
            run_instr(0, 0, 0);
            if (m_halt) begin
                halt_cycles(3);
                do_reset();
            end
        end

        exp_chk = 1'b0;
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
